// File: rtl/hermes_inj_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one Hermes boundary input port between N_SRC injectors.
// Latency: 1 cycle, through a one-entry output register. Backpressure: all source credits drop while the register is full and the router withholds credit.
module hermes_inj_port_arbiter #(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SRC-1:0]           src_rx_i,
    output logic [N_SRC-1:0]           src_credit_o,
    input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
    input  logic                       release_i,
    output logic                       noc_tx_o,
    input  logic                       noc_credit_i,
    output logic [FLIT_SIZE-1:0]       noc_data_o,
    output logic [N_SRC-1:0]           grant_o,
    output logic                       busy_o
);
    localparam int SW = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        PAYLOAD
    } state_t;

    state_t               state;
    logic [SW-1:0]        rr;
    logic [SW-1:0]        gnt_idx;
    logic [N_SRC-1:0]     grant;
    logic [FLIT_SIZE-1:0] remaining;
    logic                 out_vld;
    logic [FLIT_SIZE-1:0] out_dat;

    logic [SW-1:0]        sel;
    logic                 sel_vld;
    logic                 sel_rx;
    logic [FLIT_SIZE-1:0] sel_dat;
    logic [N_SRC-1:0]     sel_oh;
    logic [SW:0]          cand_sum;
    logic [SW-1:0]        cand;
    logic [SW-1:0]        rr_next;
    logic                 slot_free;
    logic                 xfer;
    logic                 pkt_end;

    // In IDLE the search starts at rr and wraps; mid-packet only the granted source is served.
    always_comb begin
        sel      = gnt_idx;
        sel_vld  = 1'b0;
        cand_sum = '0;
        cand     = '0;
        if (state == IDLE) begin
            sel = rr;
            if (release_i) begin
                for (int k = 0; k < N_SRC; k++) begin
                    cand_sum = {1'b0, rr} + (SW+1)'(k);
                    if (cand_sum >= (SW+1)'(N_SRC)) begin
                        cand_sum = cand_sum - (SW+1)'(N_SRC);
                    end
                    cand = cand_sum[SW-1:0];
                    if (!sel_vld && src_rx_i[cand]) begin
                        sel_vld = 1'b1;
                        sel     = cand;
                    end
                end
            end
        end else begin
            sel_vld = 1'b1;
        end
    end

    always_comb begin
        sel_dat = '0;
        sel_oh  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_oh[i] = (sel == SW'(i));
            if (sel == SW'(i)) begin
                sel_dat = src_data_i[i*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    assign sel_rx    = src_rx_i[sel];
    assign slot_free = !out_vld || noc_credit_i;
    assign xfer      = sel_vld && slot_free && sel_rx;
    assign rr_next   = (gnt_idx == SW'(N_SRC-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_credit_o[i] = slot_free && sel_vld && sel_oh[i];
        end
    end

    // Packet tail: zero-size packet ends on its size flit, otherwise on the last payload flit.
    always_comb begin
        pkt_end = 1'b0;
        if (state == SIZE) begin
            pkt_end = (sel_dat == '0);
        end else if (state == PAYLOAD) begin
            pkt_end = (remaining == FLIT_SIZE'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr        <= '0;
            gnt_idx   <= '0;
            grant     <= '0;
            remaining <= '0;
            out_vld   <= 1'b0;
            out_dat   <= '0;
        end else begin
            if (xfer) begin
                out_vld <= 1'b1;
                out_dat <= sel_dat;
            end else if (noc_credit_i) begin
                out_vld <= 1'b0;
            end

            if (xfer) begin
                case (state)
                    IDLE: begin
                        state   <= SIZE;
                        gnt_idx <= sel;
                        grant   <= sel_oh;
                    end
                    SIZE: begin
                        remaining <= sel_dat;
                        if (pkt_end) begin
                            state <= IDLE;
                            grant <= '0;
                            rr    <= rr_next;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        remaining <= remaining - 1'b1;
                        if (pkt_end) begin
                            state <= IDLE;
                            grant <= '0;
                            rr    <= rr_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        grant <= '0;
                    end
                endcase
            end
        end
    end

    assign noc_tx_o   = out_vld;
    assign noc_data_o = out_dat;
    assign grant_o    = grant;
    assign busy_o     = (state != IDLE) || out_vld;

endmodule

// File: tb/tb_hermes_inj_port_arbiter.sv
// Bench for hermes_inj_port_arbiter: directed scenarios plus randomized traffic against a packet-level round-robin model.
module tb_hermes_inj_port_arbiter;
    localparam int NS = 2;
    localparam int FW = 32;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NS-1:0]  src_rx_i;
    logic [NS-1:0]  src_credit_o;
    logic [NS*FW-1:0] src_data_i;
    logic           release_i;
    logic           noc_tx_o;
    logic           noc_credit_i;
    logic [FW-1:0]  noc_data_o;
    logic [NS-1:0]  grant_o;
    logic           busy_o;

    always #5 clk = ~clk;

    hermes_inj_port_arbiter #(.N_SRC(NS), .FLIT_SIZE(FW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_rx_i     (src_rx_i),
        .src_credit_o (src_credit_o),
        .src_data_i   (src_data_i),
        .release_i    (release_i),
        .noc_tx_o     (noc_tx_o),
        .noc_credit_i (noc_credit_i),
        .noc_data_o   (noc_data_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Source-side flit queues driven onto the DUT, and the model's own copy of the same packets.
    logic [FW-1:0] srcq [NS][$];
    logic [FW-1:0] mq   [NS][$];
    int            plen [NS][$];

    int            exp_src [$];
    logic [FW-1:0] exp_flit[$];
    bit            exp_hdr [$];
    int            acc_idx, out_idx, model_rr;
    int            hdr_cyc[$], hdr_src[$], out_cyc[$];
    int            ph_cyc, stall_seen;
    bit            rel_drv, rel_rand;
    int            nc_mode, stall_lo, stall_hi;
    bit            last_acc_vld, hold_vld;
    logic [FW-1:0] last_acc_dat, hold_dat;

    task automatic add_pkt(input int s, input logic [FW-1:0] hdr, input int sz, input logic [FW-1:0] base);
        logic [FW-1:0] f[$];
        f.push_back(hdr);
        f.push_back(FW'(sz));
        for (int j = 0; j < sz; j++) f.push_back(base + FW'(j));
        foreach (f[k]) begin
            srcq[s].push_back(f[k]);
            mq[s].push_back(f[k]);
        end
        plen[s].push_back(sz + 2);
    endtask

    // Whole packets leave in round-robin order among sources that still hold packets.
    function automatic void build_expect();
        bit any;
        int idx, len;
        do begin
            any = 1'b0;
            for (int k = 0; k < NS; k++) begin
                idx = (model_rr + k) % NS;
                if (!any && plen[idx].size() > 0) begin
                    any = 1'b1;
                    len = plen[idx].pop_front();
                    for (int j = 0; j < len; j++) begin
                        exp_src.push_back(idx);
                        exp_flit.push_back(mq[idx].pop_front());
                        exp_hdr.push_back(j == 0);
                    end
                    model_rr = (idx + 1) % NS;
                end
            end
        end while (any);
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            src_rx_i[i] = (srcq[i].size() != 0);
            src_data_i[i*FW +: FW] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
        end
        release_i = rel_rand ? ($urandom_range(0, 3) != 0) : rel_drv;
        case (nc_mode)
            1:       noc_credit_i = ($urandom_range(0, 3) != 0);
            2:       noc_credit_i = !(ph_cyc >= stall_lo && ph_cyc < stall_hi);
            default: noc_credit_i = 1'b1;
        endcase
    endtask

    task automatic step();
        bit [NS-1:0] acc;
        drive();
        #1;
        if (last_acc_vld) begin
            chk("lat_tx", noc_tx_o, 1);
            chk("lat_dat", noc_data_o, last_acc_dat);
        end
        if (hold_vld) begin
            chk("hold_tx", noc_tx_o, 1);
            chk("hold_dat", noc_data_o, hold_dat);
        end
        last_acc_vld = 1'b0;
        hold_vld     = 1'b0;
        if (noc_tx_o && !noc_credit_i) begin
            chk("stall_credit", src_credit_o, 0);
            hold_vld = 1'b1;
            hold_dat = noc_data_o;
            stall_seen++;
        end
        if (noc_tx_o && noc_credit_i) begin
            if (out_idx < exp_flit.size()) chk("out_dat", noc_data_o, exp_flit[out_idx]);
            else chk("out_extra", out_idx, exp_flit.size());
            out_cyc.push_back(ph_cyc);
            out_idx++;
        end
        acc = src_rx_i & src_credit_o;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                if (acc_idx < exp_src.size()) begin
                    chk("acc_src", i, exp_src[acc_idx]);
                    if (exp_hdr[acc_idx]) begin
                        hdr_cyc.push_back(ph_cyc);
                        hdr_src.push_back(i);
                    end else begin
                        chk("grant", grant_o, NS'(1) << i);
                    end
                end else begin
                    chk("acc_extra", acc_idx, exp_src.size());
                end
                acc_idx++;
                last_acc_vld = 1'b1;
                last_acc_dat = src_data_i[i*FW +: FW];
            end
        end
        @(posedge clk);
        for (int i = 0; i < NS; i++) if (acc[i]) srcq[i].delete(0);
        ph_cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_i        = 1'b1;
        src_rx_i     = '0;
        src_data_i   = '0;
        release_i    = 1'b0;
        noc_credit_i = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            mq[i].delete();
            plen[i].delete();
        end
        exp_src.delete();
        exp_flit.delete();
        exp_hdr.delete();
        hdr_cyc.delete();
        hdr_src.delete();
        out_cyc.delete();
        acc_idx = 0; out_idx = 0; model_rr = 0; ph_cyc = 0; stall_seen = 0;
        last_acc_vld = 1'b0; hold_vld = 1'b0;
        rel_drv = 1'b1; rel_rand = 1'b0; nc_mode = 0;
    endtask

    function automatic bit src_empty();
        bit e = 1'b1;
        for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_drain(input string tag, input int budget);
        int n = 0;
        build_expect();
        while (!(src_empty() && out_idx == exp_flit.size()) && n < budget) begin
            step();
            n++;
        end
        chk(tag, out_idx, exp_flit.size());
        chk({tag, "_acc"}, acc_idx, exp_src.size());
    endtask

    initial begin
        do_reset(3);
        chk("rst_tx", noc_tx_o, 0);
        chk("rst_dat", noc_data_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_credit", src_credit_o, 0);

        // Single packet, full-rate drain.
        add_pkt(0, 32'h0000_0101, 2, 32'hA);
        run_drain("single_drain", 50);
        chk("single_nout", out_cyc.size(), 4);
        if (hdr_cyc.size() > 0)
            foreach (out_cyc[k]) chk("single_lat", out_cyc[k], hdr_cyc[0] + 1 + k);
        chk("single_busy", busy_o, 0);
        chk("single_grant_idle", grant_o, 0);

        // Round robin with both sources requesting from the first cycle.
        do_reset(1);
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < NS; s++)
                add_pkt(s, FW'(32'h100 * s + p), 1, $urandom);
        run_drain("rr_drain", 100);
        chk("rr_npkt", hdr_src.size(), 6);
        foreach (hdr_src[k]) chk("rr_order", hdr_src[k], k % 2);

        // Back-pressure for 5 cycles during the payload.
        do_reset(1);
        nc_mode = 2; stall_lo = 4; stall_hi = 9;
        add_pkt(1, 32'h0000_0202, 6, 32'h5000);
        run_drain("bp_drain", 100);
        chk("bp_stalls", stall_seen, 5);

        // Release gate.
        do_reset(1);
        rel_drv = 1'b0;
        add_pkt(1, 32'h0000_0303, 3, 32'h7000);
        build_expect();
        repeat (4) begin
            step();
            chk("rel_credit", src_credit_o, 0);
            chk("rel_tx", noc_tx_o, 0);
        end
        rel_drv = 1'b1;
        release_i = 1'b1;
        #1;
        chk("rel_grant_now", src_credit_o, 2'b10);
        step();
        step();
        rel_drv = 1'b0;
        run_drain("rel_drain", 50);
        chk("rel_nout", out_idx, 5);

        // Zero-size packet followed by another requester.
        do_reset(1);
        add_pkt(0, 32'h0000_0404, 0, 32'h0);
        add_pkt(1, 32'h0000_0505, 1, 32'h9000);
        run_drain("zero_drain", 50);
        if (hdr_cyc.size() == 2) chk("zero_gap", hdr_cyc[1] - hdr_cyc[0], 2);
        else chk("zero_hdrs", hdr_cyc.size(), 2);

        // Reset in the middle of a packet, then a fresh packet.
        do_reset(1);
        add_pkt(0, 32'h0000_0606, 6, 32'hB000);
        build_expect();
        repeat (4) step();
        chk("mid_busy_pre", busy_o, 1);
        do_reset(1);
        chk("mid_tx", noc_tx_o, 0);
        chk("mid_grant", grant_o, 0);
        chk("mid_busy", busy_o, 0);
        add_pkt(1, 32'h0000_0707, 3, 32'hC000);
        run_drain("mid_drain", 50);
        if (hdr_src.size() > 0) chk("mid_src", hdr_src[0], 1);

        // Randomized traffic, random router credit and release.
        do_reset(1);
        nc_mode  = 1;
        rel_rand = 1'b1;
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < NS; s++)
                add_pkt(s, FW'((s << 16) | p), $urandom_range(0, 5), $urandom);
        run_drain("rand_drain", 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hermes_inj_port_arbiter.md
# hermes_inj_port_arbiter

Packet-granular round-robin arbiter that lets several boundary injectors (mapper injector, application injector, future peripherals) share one Hermes boundary input port of the many-core mesh. It sits between the injectors' NoC transmit side and the router port's `rx/credit/data` input. It holds a grant for a whole Hermes packet so that flits from different sources never interleave. New grants can be blocked by the PE's peripheral-release signal.

## Interface
- `N_SRC`, default 2: number of injectors sharing the port, range 2..8; index 0 has the highest initial priority.
- `FLIT_SIZE`, default 32: flit width in bits.
- `clk_i`  in  1: clock; all state changes on the rising edge.
- `rst_i`  in  1: reset; synchronous, active-high.
- `src_rx_i`  in  N_SRC: per-source flit valid.
- `src_credit_o`  out  N_SRC: per-source accept; a flit transfers when `src_rx_i[i] && src_credit_o[i]`.
- `src_data_i`  in  N_SRC x FLIT_SIZE: per-source flit.
- `release_i`  in  1: when low, no new packet is granted; a packet already in flight completes.
- `noc_tx_o`  out  1: flit valid toward the router port.
- `noc_credit_i`  in  1: router can accept; a transfer happens when `noc_tx_o && noc_credit_i`.
- `noc_data_o`  out  FLIT_SIZE: flit toward the router.
- `grant_o`  out  N_SRC: one-hot grant of the packet in flight; all zero in IDLE.
- `busy_o`  out  1: high whenever state is not IDLE or the output register holds a flit.

## Operation
- Packet format: flit 0 is the header (target), flit 1 is the size field S (payload flit count, unsigned, full FLIT_SIZE width), followed by S payload flits. Total packet length is S+2 flits.
- Output stage: one-entry register holding `out_valid` and `out_data`. `slot_free = !out_valid || noc_credit_i`. `noc_tx_o = out_valid`, `noc_data_o = out_data`.
- `src_credit_o[i] = slot_free && (sel == i) && state-allowed`. Every other source sees 0. Non-granted sources are never consumed.
- State machine: `IDLE -> SIZE -> PAYLOAD -> IDLE`.
- **IDLE:**
  - `sel` is the first index with `src_rx_i` high, searching circularly from the round-robin pointer `rr`. The search applies only when `release_i` is high; otherwise no source is selected.
  - On a header transfer: latch `grant = onehot(sel)` and go to SIZE.
- **SIZE:**
  - Only the granted source is served.
  - On transfer: load `remaining = S`.
  - If S == 0, the packet ends: go to IDLE and set `rr = (g+1) mod N_SRC`.
  - Otherwise go to PAYLOAD.
- **PAYLOAD:**
  - Each transfer decrements `remaining`.
  - On the transfer that occurs with `remaining == 1`, the packet ends: go to IDLE and set `rr = (g+1) mod N_SRC`.
- `release_i` is sampled only in IDLE. Dropping it in SIZE or PAYLOAD has no effect on the packet in flight.
- The counter is FLIT_SIZE wide with no saturation. S = 2^FLIT_SIZE-1 is legal (simulation only).
- Reset, including mid-packet, forces:
  - state = IDLE, `rr = 0`, `grant_o = 0`, `out_valid = 0`, `out_data = 0`, `remaining = 0`.
  - The partially sent packet is abandoned. The downstream port is assumed to be reset together with this block.

## Timing
- Reset values: `noc_tx_o = 0`, `noc_data_o = 0`, `grant_o = 0`, `busy_o = 0`, `src_credit_o = 0`.
- `src_credit_o` is combinational from `src_rx_i`, `release_i`, state, `rr`, `out_valid` and `noc_credit_i`.
- Latency: a flit accepted from a source on cycle t is on `noc_data_o` with `noc_tx_o = 1` from cycle t+1.
- Throughput: 1 flit/cycle sustained while `noc_credit_i = 1`.
- Simultaneous drain and fill in the same cycle is allowed. The register takes the new flit and `out_valid` stays 1.
- Back-to-back packets:
  - The header of the next packet may be granted on the cycle after the last flit of the previous one (IDLE lasts 1 cycle minimum).
  - No idle cycle is required on `noc_tx_o` if the next header is accepted while the previous tail drains.
- When `noc_credit_i = 0` and `out_valid = 1`:
  - `noc_data_o` is held stable.
  - All `src_credit_o` are 0.

## Test plan
- **Single packet:** reset, then source 0 sends header 0x00000101, size 2, payload 0xA, 0xB with `noc_credit_i = 1`.
  - Router sees the 4 flits on consecutive cycles starting 1 cycle after the header is accepted.
  - `grant_o = 01` during the packet; `busy_o` falls after the last flit drains.
- **Round robin:** both sources hold 3 packets each (S = 1), all valid from cycle 0.
  - Packet order is 0, 1, 0, 1, 0, 1 with no flit interleaving.
  - `rr` alternates between 1 and 0.
- **Back-pressure:** during the payload, `noc_credit_i` is 0 for 5 cycles.
  - `noc_data_o` holds its value, `src_credit_o = 0`, no flit is lost or duplicated.
  - Sent packet equals received packet.
- **Release gate:**
  - With `release_i = 0`, source 1 asserting rx gets no credit and `noc_tx_o` stays 0.
  - Raising `release_i` grants source 1 on that same cycle.
  - Dropping `release_i` mid-payload still lets the packet complete.
- **Zero-size packet:** a header plus S = 0 returns to IDLE after 2 flits, and the next requester is granted on the following cycle.
- **Reset mid-packet:** assert `rst_i` for 1 cycle during the payload.
  - Next cycle: `noc_tx_o = 0`, `grant_o = 0`, state IDLE.
  - A fresh packet from source 1 then passes intact.
